// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light controller and the conflict monitor:
//   - one-hot light encodings (red/yellow/green/off)
//   - monitor fault-cause codes
//   - monitor state enumeration
//   - classify_lights(): per-cycle violation classification of an NS/EW pair
// -----------------------------------------------------------------------------
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_CONFLICT   = 2'b01;
  localparam logic [1:0] FAULT_NS_INVALID = 2'b10;
  localparam logic [1:0] FAULT_EW_INVALID = 2'b11;

  typedef enum logic [1:0] {
    MON_STARTUP = 2'b00,
    MON_PASS    = 2'b01,
    MON_FLASH   = 2'b10
  } mon_state_t;

  function automatic logic light_valid(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

  // Priority: NS encoding, then EW encoding, then right-of-way conflict.
  function automatic logic [1:0] classify_lights(input logic [2:0] ns,
                                                 input logic [2:0] ew);
    logic [1:0] cause;
    cause = FAULT_NONE;
    if (!light_valid(ns)) begin
      cause = FAULT_NS_INVALID;
    end else if (!light_valid(ew)) begin
      cause = FAULT_EW_INVALID;
    end else if ((ns != LIGHT_RED) && (ew != LIGHT_RED)) begin
      cause = FAULT_CONFLICT;
    end
    return cause;
  endfunction

endpackage

// File: rtl/lamp_flasher.sv
// -----------------------------------------------------------------------------
// lamp_flasher
// Half-period divider for fault flashing. While enabled, a counter wraps over
// 0..FLASH_HALF-1 and the phase toggles at each wrap. While disabled it is held
// at count 0 with phase on, so every enable starts with a full "on" phase.
// Ports:
//   clk      in  1  rising-edge clock
//   rst      in  1  synchronous active-high reset
//   en       in  1  run enable
//   phase_on out 1  1 = lamps lit (all-red), 0 = lamps dark
// -----------------------------------------------------------------------------
module lamp_flasher #(
  parameter int FLASH_HALF = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_on
);

  localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (cnt == CW'(FLASH_HALF - 1)) begin
      cnt      <= '0;
      phase_on <= ~phase_on;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
// Safety stage between the traffic light controller and the physical lamps.
// Holds all-red for STARTUP_RED cycles after reset or a fault clear, then
// passes clean controller codes to the lamps with one cycle of latency.
// Violating codes never reach the lamps; PERSIST consecutive violations latch
// a fault and force flashing all-red until an operator clear arrives on a
// cycle with clean inputs.
// Ports:
//   clk          in  1  rising-edge clock
//   rst          in  1  synchronous active-high reset
//   ns_light_in  in  3  NS code from controller
//   ew_light_in  in  3  EW code from controller
//   clear_fault  in  1  operator fault clear (level, honoured only in FLASH)
//   ns_lamp      out 3  NS lamp drive
//   ew_lamp      out 3  EW lamp drive
//   fault        out 1  latched fault flag
//   fault_code   out 2  cause captured on the latching cycle
// -----------------------------------------------------------------------------
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int FLASH_HALF  = 25000,
  parameter int PERSIST     = 3,
  parameter int STARTUP_RED = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ns_light_in,
  input  logic [2:0] ew_light_in,
  input  logic       clear_fault,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int PCW = $clog2(PERSIST + 1);
  localparam int SCW = (STARTUP_RED > 1) ? $clog2(STARTUP_RED) : 1;

  mon_state_t     state;
  logic [SCW-1:0] startup_cnt;
  logic [PCW-1:0] persist_cnt;
  logic [PCW-1:0] persist_next;
  logic [1:0]     viol_code;
  logic           clean;
  logic [2:0]     ns_hold;
  logic [2:0]     ew_hold;
  logic           phase_on;

  assign viol_code    = classify_lights(ns_light_in, ew_light_in);
  assign clean        = (viol_code == FAULT_NONE);
  assign persist_next = persist_cnt + 1'b1;

  lamp_flasher #(
    .FLASH_HALF(FLASH_HALF)
  ) u_flasher (
    .clk      (clk),
    .rst      (rst),
    .en       (state == MON_FLASH),
    .phase_on (phase_on)
  );

  // Control: state, counters and fault latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MON_STARTUP;
      startup_cnt <= '0;
      persist_cnt <= '0;
      fault       <= 1'b0;
      fault_code  <= FAULT_NONE;
    end else begin
      case (state)
        MON_STARTUP: begin
          persist_cnt <= '0;
          if (startup_cnt == SCW'(STARTUP_RED - 1)) begin
            startup_cnt <= '0;
            state       <= MON_PASS;
          end else begin
            startup_cnt <= startup_cnt + 1'b1;
          end
        end
        MON_PASS: begin
          if (clean) begin
            persist_cnt <= '0;
          end else begin
            persist_cnt <= persist_next;
            // The cause may change during the run; the latching cycle's wins.
            if (persist_next == PCW'(PERSIST)) begin
              state      <= MON_FLASH;
              fault      <= 1'b1;
              fault_code <= viol_code;
            end
          end
        end
        MON_FLASH: begin
          if (clear_fault && clean) begin
            state       <= MON_STARTUP;
            startup_cnt <= '0;
            persist_cnt <= '0;
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
          end
        end
        default: begin
          state <= MON_STARTUP;
        end
      endcase
    end
  end

  // Pass-through lamp register: preloaded to red during startup so a
  // violation on the first PASS cycle holds all-red.
  always_ff @(posedge clk) begin
    if (state == MON_STARTUP) begin
      ns_hold <= LIGHT_RED;
      ew_hold <= LIGHT_RED;
    end else if ((state == MON_PASS) && clean) begin
      ns_hold <= ns_light_in;
      ew_hold <= ew_light_in;
    end
  end

  // Lamp drive is a mux of registered state only, so lamps change on the
  // same edge that changes state (fault latch, clear, reset).
  always_comb begin
    ns_lamp = LIGHT_RED;
    ew_lamp = LIGHT_RED;
    case (state)
      MON_PASS: begin
        ns_lamp = ns_hold;
        ew_lamp = ew_hold;
      end
      MON_FLASH: begin
        if (!phase_on) begin
          ns_lamp = LIGHT_OFF;
          ew_lamp = LIGHT_OFF;
        end
      end
      default: begin
        ns_lamp = LIGHT_RED;
        ew_lamp = LIGHT_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_conflict_monitor
// Table-driven directed vectors, a hand-written reset-during-flash sequence,
// and a randomized phase checked against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_traffic_conflict_monitor;

  localparam int FH = 4;
  localparam int PS = 3;
  localparam int SR = 5;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk;
  logic       rst;
  logic [2:0] ns_in;
  logic [2:0] ew_in;
  logic       clr;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       fault;
  logic [1:0] fault_code;

  int checks;
  int failures;

  traffic_conflict_monitor #(
    .FLASH_HALF (FH),
    .PERSIST    (PS),
    .STARTUP_RED(SR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ns_light_in(ns_in),
    .ew_light_in(ew_in),
    .clear_fault(clr),
    .ns_lamp    (ns_lamp),
    .ew_lamp    (ew_lamp),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int         m_startup_left;
  int         m_run;
  int         m_flash_age;
  bit         m_fault;
  logic [1:0] m_code;
  logic [2:0] m_ns;
  logic [2:0] m_ew;

  function automatic logic [1:0] cause_of(input logic [2:0] n, input logic [2:0] e);
    bit nv, ev;
    nv = (n == R) || (n == Y) || (n == G);
    ev = (e == R) || (e == Y) || (e == G);
    if (!nv) return 2'b10;
    if (!ev) return 2'b11;
    if (n != R && e != R) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] n, input logic [2:0] e,
                            input logic c);
    logic [1:0] cs;
    cs = cause_of(n, e);
    if (r) begin
      m_startup_left = SR; m_run = 0; m_flash_age = 0;
      m_fault = 0; m_code = 2'b00; m_ns = R; m_ew = R;
    end else if (m_fault) begin
      m_flash_age++;
      if (c && cs == 2'b00) begin
        m_fault = 0; m_code = 2'b00; m_startup_left = SR; m_run = 0;
        m_ns = R; m_ew = R;
      end else if (((m_flash_age / FH) % 2) == 0) begin
        m_ns = R; m_ew = R;
      end else begin
        m_ns = O; m_ew = O;
      end
    end else if (m_startup_left > 0) begin
      m_startup_left--; m_run = 0; m_ns = R; m_ew = R;
    end else if (cs == 2'b00) begin
      m_run = 0; m_ns = n; m_ew = e;
    end else begin
      m_run++;
      if (m_run == PS) begin
        m_fault = 1; m_code = cs; m_flash_age = 0; m_ns = R; m_ew = R;
      end
    end
  endtask

  // ---------------- drive / check helpers ----------------
  task automatic tick(input logic r, input logic [2:0] n, input logic [2:0] e,
                      input logic c);
    rst = r; ns_in = n; ew_in = e; clr = c;
    @(posedge clk);
    #1;
    model_step(r, n, e, c);
  endtask

  task automatic check(input string name, input logic [8:0] want);
    logic [8:0] got;
    got = {ns_lamp, ew_lamp, fault, fault_code};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got ns=%b ew=%b fault=%b code=%b want ns=%b ew=%b fault=%b code=%b",
               name, got[8:6], got[5:3], got[2], got[1:0],
               want[8:6], want[5:3], want[2], want[1:0]);
    end
  endtask

  typedef struct {
    logic       r;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       c;
    logic [2:0] e_ns;
    logic [2:0] e_ew;
    logic       e_f;
    logic [1:0] e_code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int cnt, input logic r, input logic [2:0] n, input logic [2:0] e,
                     input logic c, input logic [2:0] xn, input logic [2:0] xe,
                     input logic xf, input logic [1:0] xc);
    vec_t v;
    v.r = r; v.ns = n; v.ew = e; v.c = c;
    v.e_ns = xn; v.e_ew = xe; v.e_f = xf; v.e_code = xc;
    for (int k = 0; k < cnt; k++) vecs.push_back(v);
  endtask

  function automatic logic [2:0] rand_light();
    int k;
    k = $urandom_range(0, 9);
    if (k < 4) return R;
    if (k < 6) return G;
    if (k < 8) return Y;
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; ns_in = G; ew_in = R; clr = 1'b0;

    // Startup pass-through and glitch filtering
    add(1, 1, G, R, 0, R, R, 0, 2'b00);
    add(5, 0, G, R, 0, R, R, 0, 2'b00);
    add(2, 0, G, R, 0, G, R, 0, 2'b00);
    add(2, 0, G, G, 0, G, R, 0, 2'b00);
    add(1, 0, G, R, 0, G, R, 0, 2'b00);
    // Conflict latch and flash pattern
    add(2, 0, G, Y, 0, G, R, 0, 2'b00);
    add(4, 0, G, Y, 0, R, R, 1, 2'b01);
    add(4, 0, G, Y, 0, O, O, 1, 2'b01);
    add(3, 0, G, Y, 0, R, R, 1, 2'b01);
    // Clear ignored while violating, then accepted
    add(1, 0, G, G, 1, R, R, 1, 2'b01);
    add(1, 0, R, G, 1, R, R, 0, 2'b00);
    add(5, 0, R, G, 0, R, R, 0, 2'b00);
    add(1, 0, R, G, 0, R, G, 0, 2'b00);
    // NS invalid
    add(2, 0, 3'b011, R, 0, R, G, 0, 2'b00);
    add(1, 0, 3'b011, R, 0, R, R, 1, 2'b10);
    add(1, 0, R, R, 1, R, R, 0, 2'b00);
    add(5, 0, R, Y, 0, R, R, 0, 2'b00);
    add(1, 0, R, Y, 0, R, Y, 0, 2'b00);
    // EW invalid
    add(2, 0, R, 3'b110, 0, R, Y, 0, 2'b00);
    add(1, 0, R, 3'b110, 0, R, R, 1, 2'b11);
    add(1, 0, R, R, 1, R, R, 0, 2'b00);
    add(5, 0, G, R, 0, R, R, 0, 2'b00);
    add(1, 0, G, R, 0, G, R, 0, 2'b00);
    // Both invalid: NS has priority
    add(2, 0, O, 3'b111, 0, G, R, 0, 2'b00);
    add(1, 0, O, 3'b111, 0, R, R, 1, 2'b10);
    // Cause changes during persistence: latching cycle's cause wins
    add(1, 0, R, R, 1, R, R, 0, 2'b00);
    add(5, 0, R, G, 0, R, R, 0, 2'b00);
    add(1, 0, R, G, 0, R, G, 0, 2'b00);
    add(1, 0, G, G, 0, R, G, 0, 2'b00);
    add(1, 0, 3'b110, R, 0, R, G, 0, 2'b00);
    add(1, 0, R, 3'b011, 0, R, R, 1, 2'b11);
    // clear_fault held through STARTUP and PASS has no effect there
    add(1, 0, R, R, 1, R, R, 0, 2'b00);
    add(5, 0, G, R, 1, R, R, 0, 2'b00);
    add(2, 0, G, R, 1, G, R, 0, 2'b00);
    add(2, 0, Y, Y, 1, G, R, 0, 2'b00);
    add(1, 0, Y, Y, 1, R, R, 1, 2'b01);
    add(1, 0, Y, Y, 1, R, R, 1, 2'b01);
    add(1, 0, R, R, 1, R, R, 0, 2'b00);
    add(5, 0, G, R, 0, R, R, 0, 2'b00);
    add(1, 0, G, R, 0, G, R, 0, 2'b00);

    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].ns, vecs[i].ew, vecs[i].c);
      check($sformatf("vec%0d", i),
            {vecs[i].e_ns, vecs[i].e_ew, vecs[i].e_f, vecs[i].e_code});
    end

    // Reset during the off phase of flashing
    tick(0, G, G, 0); check("rst_seq_hold1", {G, R, 1'b0, 2'b00});
    tick(0, G, G, 0); check("rst_seq_hold2", {G, R, 1'b0, 2'b00});
    tick(0, G, G, 0); check("rst_seq_latch", {R, R, 1'b1, 2'b01});
    for (int k = 0; k < 3; k++) tick(0, G, G, 0);
    tick(0, G, G, 0); check("rst_seq_off", {O, O, 1'b1, 2'b01});
    tick(1, G, G, 0); check("rst_seq_reset", {R, R, 1'b0, 2'b00});
    for (int k = 0; k < SR; k++) begin
      tick(0, Y, R, 0);
      check($sformatf("rst_seq_startup%0d", k), {R, R, 1'b0, 2'b00});
    end
    tick(0, Y, R, 0); check("rst_seq_pass", {Y, R, 1'b0, 2'b00});

    // Randomized run against the reference model
    for (int k = 0; k < 3000; k++) begin
      tick(($urandom_range(0, 299) == 0), rand_light(), rand_light(),
           ($urandom_range(0, 5) == 0));
      check($sformatf("rand%0d", k), {m_ns, m_ew, m_fault, m_code});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Safety stage directly downstream of the traffic light controller. It consumes the controller's NS/EW light codes, checks every cycle for illegal encodings and conflicting right-of-way, and drives the physical lamp outputs. Clean codes pass through registered. A persistent violation latches a fault and forces flashing all-red until an operator clear. After reset it holds an all-red clearance interval before passing any controller output.

## Interface
Parameters:
- `FLASH_HALF`, default 25000: cycles per half-period of fault flashing. Must be ≥1.
- `PERSIST`, default 3: consecutive violating cycles required to latch a fault. Must be ≥1.
- `STARTUP_RED`, default 1000: all-red clearance cycles after reset or after a fault clear. Must be ≥1.

Ports:
- `clk`, in, 1: single clock. Rising edge only.
- `rst`, in, 1: synchronous, active-high reset.
- `ns_light_in`, in, 3: NS code from the controller.
- `ew_light_in`, in, 3: EW code from the controller.
- `clear_fault`, in, 1: operator fault clear. Level-sampled.
- `ns_lamp`, out, 3: NS lamp drive.
- `ew_lamp`, out, 3: EW lamp drive.
- `fault`, out, 1: latched fault flag.
- `fault_code`, out, 2: cause of the latched fault.

## Operation
- Light encoding: red = 100, yellow = 010, green = 001, off = 000.
- Valid code: exactly one of {100, 010, 001}.
- Violation is evaluated each cycle. Priority, highest first:
  - NS code invalid → code 10.
  - EW code invalid → code 11.
  - Both codes valid and neither is red → code 01 (conflict).
  - Otherwise clean → code 00.
- States: STARTUP, PASS, FLASH.
- STARTUP:
  - Lamps are 100/100.
  - Inputs are not checked.
  - A counter runs 0..STARTUP_RED-1, then the block moves to PASS.
- PASS:
  - Clean cycle: lamps take the input codes and the persistence counter clears to 0.
  - Violating cycle: lamps hold their previous value and the persistence counter increments. A violating code never reaches the lamps.
  - When the counter reaches PERSIST, the block enters FLASH, sets `fault` to 1, and captures that cycle's violation code into `fault_code`.
  - Persistence counter width: $clog2(PERSIST+1).
- FLASH:
  - The flash counter wraps over 0..FLASH_HALF-1 and toggles the phase at each wrap.
  - Phase on: lamps 100/100. Phase off: lamps 000/000.
  - The first phase after entry is on.
- Clear:
  - `clear_fault` is honoured only in FLASH.
  - It takes effect only if the inputs are clean on that cycle. The block then goes to STARTUP, and `fault` and `fault_code` return to 0.
  - If the inputs are violating, the clear is ignored.
  - In STARTUP and PASS, `clear_fault` has no effect.

## Timing
- Reset values: `ns_lamp` = 100, `ew_lamp` = 100, `fault` = 0, `fault_code` = 00, state STARTUP, all counters 0.
- Reset mid-operation, in any state, produces these values at the next edge.
- STARTUP length: lamps are all-red for exactly STARTUP_RED edges after `rst` deasserts. The input sampled at edge STARTUP_RED+1 appears on the lamps after that edge.
- PASS latency: exactly 1 cycle from input to lamp.
- Fault latch: on the edge sampling the PERSIST-th consecutive violation, `fault` rises and the lamps go 100/100 on that same edge.
- Flash timing: phase on lasts FLASH_HALF edges, then phase off lasts FLASH_HALF edges, repeating.
- Clear timing:
  - `fault` falls on the edge that samples the clear.
  - STARTUP_RED all-red edges follow, then PASS resumes.
  - The flash phase does not matter; the lamps become 100/100 immediately.
- Persistence reset: a single clean cycle resets the persistence count. Alternating violating and clean cycles never latch a fault when PERSIST > 1.
- Fault code on change of cause: if the violation type changes during persistence, the count continues and the code is the one from the latching cycle.

## Structure
- Shared package `traffic_pkg` holds:
  - Light encodings `LIGHT_RED`, `LIGHT_YELLOW`, `LIGHT_GREEN`, `LIGHT_OFF`.
  - Fault-code constants `FAULT_NONE`, `FAULT_CONFLICT`, `FAULT_NS_INVALID`, `FAULT_EW_INVALID`.
  - The monitor state enum.
- The controller and this monitor both import `traffic_pkg`.
- One sub-module, `lamp_flasher`:
  - Behaviour: a parameterised FLASH_HALF divider with enable.
  - Output: `phase_on`.
  - Enable low: resets to phase on with count 0.

## Test plan
All scenarios use FLASH_HALF=4, PERSIST=3, STARTUP_RED=5.
- **Startup pass-through:** release reset with inputs NS=001, EW=100. Lamps are 100/100 for 5 edges, then 001/100 after edge 6. `fault` stays 0.
- **Glitch filtering:** in PASS, hold 001/100, then drive 001/001 for 2 cycles, then 001/100. Lamps stay 001/100 throughout and `fault` stays 0.
- **Conflict latch:** drive 001/010 for 3 cycles. On the 3rd edge `fault`=1 and `fault_code`=01. Lamps then cycle 100/100 ×4, 000/000 ×4, repeating.
- **Code priority:**
  - NS=011, EW=100 held → code 10.
  - NS=100, EW=110 → code 11.
  - NS=000, EW=111 → code 10.
- **Clear:**
  - `clear_fault`=1 with inputs 001/001 → remains FLASH, `fault`=1.
  - `clear_fault`=1 with inputs 100/001 → `fault`=0 and lamps 100/100 for 5 edges, then 100/001.
- **Reset mid-flash:** assert `rst` for 1 cycle during phase off. The next edge gives 100/100 with `fault`=0, and STARTUP restarts for 5 edges.
